// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-in / frame-out bundle of the UART frame controller.
// The receiver side (master) presents a byte with a one-cycle strobe. The
// controller (slave) answers with registered strobes.
// Handshake: i_Rx_DV is a single-cycle strobe with no backpressure. The
// controller samples i_Rx_Byte on every clock where i_Rx_DV=1.
// o_Data_Valid, o_Frame_Done and o_Frame_Error are single-cycle strobes.
// No downstream ready signal exists.
interface uart_rx_frame_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             i_Rx_DV;
  logic [7:0]       i_Rx_Byte;
  logic             o_Data_Valid;
  logic [7:0]       o_Data_Byte;
  logic [IDX_W-1:0] o_Data_Index;
  logic             o_Frame_Done;
  logic             o_Frame_Error;
  logic [1:0]       o_Err_Code;
  logic             o_Busy;
  logic [1:0]       o_State;    // debug view of the frame FSM

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Data_Valid, o_Data_Byte, o_Data_Index,
    input  o_Frame_Done, o_Frame_Error, o_Err_Code, o_Busy, o_State
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Data_Valid, o_Data_Byte, o_Data_Index,
    output o_Frame_Done, o_Frame_Error, o_Err_Code, o_Busy, o_State
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind a UART receiver.
// The frame format is SYNC, LEN, LEN payload bytes, then CHK.
// Payload bytes are forwarded one clock after their strobe.
// The checksum is the XOR of LEN and every payload byte.
// Errors report bad LEN, checksum mismatch or an inter-byte timeout.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         IDX_W        = 4,
  parameter int         TIMEOUT_CLKS = 1740
) (
  input logic                 i_Clock,
  input logic                 i_Reset,
  uart_rx_frame_ctrl_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CLKS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       LEN_MAX  = 8'(MAX_LEN);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHK     = 2'd3;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  logic [1:0]       state;
  logic [7:0]       len;
  logic [7:0]       count;
  logic [7:0]       chk;
  logic [TMR_W-1:0] timer;

  logic             data_valid;
  logic [7:0]       data_byte;
  logic [IDX_W-1:0] data_index;
  logic             frame_done;
  logic             frame_error;
  logic [1:0]       err_code;

  // Frame FSM. An incoming byte always wins over a timer expiry in the same cycle.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      len         <= 8'd0;
      count       <= 8'd0;
      chk         <= 8'd0;
      timer       <= '0;
      data_valid  <= 1'b0;
      data_byte   <= 8'd0;
      data_index  <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (bus.i_Rx_DV) begin
        timer <= '0;
        case (state)
          ST_IDLE: begin
            // Anything other than the marker is line noise between frames.
            if (bus.i_Rx_Byte == SYNC_BYTE) state <= ST_LEN;
          end
          ST_LEN: begin
            if (bus.i_Rx_Byte == 8'd0 || bus.i_Rx_Byte > LEN_MAX) begin
              frame_error <= 1'b1;
              err_code    <= ERR_LEN;
              state       <= ST_IDLE;
            end else begin
              len   <= bus.i_Rx_Byte;
              chk   <= bus.i_Rx_Byte;
              count <= 8'd0;
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            data_valid <= 1'b1;
            data_byte  <= bus.i_Rx_Byte;
            data_index <= count[IDX_W-1:0];
            chk        <= chk ^ bus.i_Rx_Byte;
            count      <= count + 8'd1;
            if (count == len - 8'd1) state <= ST_CHK;
          end
          default: begin
            if (bus.i_Rx_Byte == chk) begin
              frame_done <= 1'b1;
            end else begin
              frame_error <= 1'b1;
              err_code    <= ERR_CHK;
            end
            state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (timer == TMR_LAST) begin
          frame_error <= 1'b1;
          err_code    <= ERR_TMO;
          state       <= ST_IDLE;
          timer       <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

  assign bus.o_Data_Valid  = data_valid;
  assign bus.o_Data_Byte   = data_byte;
  assign bus.o_Data_Index  = data_index;
  assign bus.o_Frame_Done  = frame_done;
  assign bus.o_Frame_Error = frame_error;
  assign bus.o_Err_Code    = err_code;
  assign bus.o_Busy        = (state != ST_IDLE);
  assign bus.o_State       = state;
endmodule
